// File: rtl/oled_cmd_ctrl.sv
// SSD1306-style command decoder and windowed frame-buffer write addressing.
// Optional end-of-window pulse on frame_done is built only when FRAME_DONE_EN is defined.
module oled_cmd_ctrl #(
    parameter logic [1:0] RESET_MODE     = 2'd0,
    parameter logic       RESET_INVERT   = 1'b0,
    parameter logic [7:0] RESET_CONTRAST = 8'h7F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic       oled_dc,
    input  logic [7:0] oled_data,
    output logic       fb_we,
    output logic [9:0] fb_waddr,
    output logic [7:0] fb_wdata,
    output logic       invert,
    output logic       display_on,
    output logic [7:0] contrast,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        CMD,
        ARG_MODE,
        ARG_CONTRAST,
        ARG_COL0,
        ARG_COL1,
        ARG_PAGE0,
        ARG_PAGE1
    } state_t;

    localparam logic [1:0] MODE_HORIZ = 2'd0;
    localparam logic [1:0] MODE_VERT  = 2'd1;
    localparam logic [1:0] MODE_PAGE  = 2'd2;

    state_t     state, state_n;
    logic [1:0] mode, mode_n;
    logic [6:0] col_start, col_start_n, col_end, col_end_n, col_ptr, col_ptr_n;
    logic [2:0] page_start, page_start_n, page_end, page_end_n, page_ptr, page_ptr_n;
    logic       invert_n, display_on_n, fb_we_n, frame_done_n;
    logic [7:0] contrast_n, fb_wdata_n;
    logic [9:0] fb_waddr_n;

    logic       col_wrap, page_wrap;
    logic [6:0] col_adv;
    logic [2:0] page_adv;

    assign col_wrap  = (col_ptr == col_end);
    assign page_wrap = (page_ptr == page_end);
    // Pointers outside the window keep counting until they hit the end value.
    assign col_adv   = col_wrap ? col_start : col_ptr + 7'd1;
    assign page_adv  = page_wrap ? page_start : page_ptr + 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CMD;
            mode       <= RESET_MODE;
            col_start  <= 7'd0;
            col_end    <= 7'd127;
            col_ptr    <= 7'd0;
            page_start <= 3'd0;
            page_end   <= 3'd7;
            page_ptr   <= 3'd0;
            invert     <= RESET_INVERT;
            display_on <= 1'b0;
            contrast   <= RESET_CONTRAST;
            fb_we      <= 1'b0;
            fb_waddr   <= 10'd0;
            fb_wdata   <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            mode       <= mode_n;
            col_start  <= col_start_n;
            col_end    <= col_end_n;
            col_ptr    <= col_ptr_n;
            page_start <= page_start_n;
            page_end   <= page_end_n;
            page_ptr   <= page_ptr_n;
            invert     <= invert_n;
            display_on <= display_on_n;
            contrast   <= contrast_n;
            fb_we      <= fb_we_n;
            fb_waddr   <= fb_waddr_n;
            fb_wdata   <= fb_wdata_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        mode_n       = mode;
        col_start_n  = col_start;
        col_end_n    = col_end;
        col_ptr_n    = col_ptr;
        page_start_n = page_start;
        page_end_n   = page_end;
        page_ptr_n   = page_ptr;
        invert_n     = invert;
        display_on_n = display_on;
        contrast_n   = contrast;
        fb_we_n      = 1'b0;
        fb_waddr_n   = fb_waddr;
        fb_wdata_n   = fb_wdata;
        frame_done_n = 1'b0;

        if (byte_valid && oled_dc) begin
            // A data byte abandons any half-received command.
            state_n    = CMD;
            fb_we_n    = 1'b1;
            fb_waddr_n = {page_ptr, col_ptr};
            fb_wdata_n = oled_data;
`ifdef FRAME_DONE_EN
            frame_done_n = (mode == MODE_PAGE) ? col_wrap : (col_wrap && page_wrap);
`endif
            case (mode)
                MODE_HORIZ: begin
                    col_ptr_n = col_adv;
                    if (col_wrap) page_ptr_n = page_adv;
                end
                MODE_VERT: begin
                    page_ptr_n = page_adv;
                    if (page_wrap) col_ptr_n = col_adv;
                end
                default: col_ptr_n = col_adv;
            endcase
        end else if (byte_valid) begin
            state_n = CMD;
            case (state)
                CMD: begin
                    if (oled_data == 8'h20) state_n = ARG_MODE;
                    else if (oled_data == 8'h81) state_n = ARG_CONTRAST;
                    else if (oled_data == 8'h21) state_n = ARG_COL0;
                    else if (oled_data == 8'h22) state_n = ARG_PAGE0;
                    else if (oled_data == 8'hA6) invert_n = 1'b0;
                    else if (oled_data == 8'hA7) invert_n = 1'b1;
                    else if (oled_data == 8'hAE) display_on_n = 1'b0;
                    else if (oled_data == 8'hAF) display_on_n = 1'b1;
                    else if (mode == MODE_PAGE) begin
                        if (oled_data[7:3] == 5'b10110) page_ptr_n = oled_data[2:0];
                        else if (oled_data[7:4] == 4'h0) col_ptr_n[3:0] = oled_data[3:0];
                        else if (oled_data[7:3] == 5'b00010) col_ptr_n[6:4] = oled_data[2:0];
                    end
                end
                ARG_MODE:     if (oled_data[1:0] != 2'd3) mode_n = oled_data[1:0];
                ARG_CONTRAST: contrast_n = oled_data;
                ARG_COL0: begin
                    col_start_n = oled_data[6:0];
                    state_n     = ARG_COL1;
                end
                ARG_COL1: begin
                    col_end_n = oled_data[6:0];
                    col_ptr_n = col_start;
                end
                ARG_PAGE0: begin
                    page_start_n = oled_data[2:0];
                    state_n      = ARG_PAGE1;
                end
                ARG_PAGE1: begin
                    page_end_n = oled_data[2:0];
                    page_ptr_n = page_start;
                end
                default: state_n = CMD;
            endcase
        end
    end

endmodule

// File: doc/oled_cmd_ctrl.md
Name: oled_cmd_ctrl

Overview:
- Command/address controller sitting between the OLED byte receiver and the 1024-byte (128x8-page) frame buffer.
- Decodes SSD1306-style command bytes (dc=0) and sequences the frame-buffer write address for data bytes (dc=1).
- Exports display configuration (invert, display on/off, contrast) to the video scan-out logic.
- Replaces the "dc low resets write pointer to 0" scheme with proper windowed addressing.

Parameters:
- RESET_MODE, 0, addressing mode after reset: 0=horizontal, 1=vertical, 2=page.
- RESET_INVERT, 0, value of invert after reset.
- RESET_CONTRAST, 8'h7F, value of contrast after reset.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- byte_valid  in  1  one-cycle strobe; the byte on oled_data/oled_dc is valid (already synchronized to clock).
- oled_dc  in  1  1=data byte, 0=command/argument byte.
- oled_data  in  8  received byte.
- fb_we  out  1  frame-buffer write enable, one cycle per data byte.
- fb_waddr  out  10  write address = page*128 + column.
- fb_wdata  out  8  write data.
- invert  out  1  display invert flag.
- display_on  out  1  display enable flag.
- contrast  out  8  contrast register.
- frame_done  out  1  end-of-window pulse (see Optional Feature).

Behaviour:
- Interface: one clock domain, clock/reset; reset is synchronous and active-high.
- Reset values:
  - fb_we=0, fb_waddr=0, fb_wdata=0, frame_done=0.
  - invert=RESET_INVERT, display_on=0, contrast=RESET_CONTRAST, mode=RESET_MODE.
  - col_start=0, col_end=127, page_start=0, page_end=7, col_ptr=0, page_ptr=0, state=CMD.
- Data byte (byte_valid & dc=1), any state:
  - Next cycle: fb_we=1, fb_waddr={page_ptr,col_ptr}, fb_wdata=byte. Latency is 1 cycle and all outputs are registered.
  - Pointers advance on the same edge that registers the write.
  - If state was an ARG state, the pending command is abandoned and state returns to CMD.
- Pointer advance:
  - Horizontal: if col_ptr==col_end, col_ptr<=col_start and the page advances; else col_ptr+1 mod 128.
  - Vertical: page advances first; on page wrap, column advances, same rules with roles swapped.
  - Page mode: column advances and wraps to col_start; page_ptr is unchanged.
  - Page advance: if page_ptr==page_end, page_ptr<=page_start; else page_ptr+1 mod 8.
  - If a pointer is beyond its end value, it counts modulo its range until it reaches end.
- Command FSM states: CMD, ARG_MODE, ARG_CONTRAST, ARG_COL0, ARG_COL1, ARG_PAGE0, ARG_PAGE1. Transitions occur only on byte_valid & dc=0.
  - CMD 0x20 -> ARG_MODE; arg[1:0] loads mode, and value 3 is ignored (mode unchanged). -> CMD.
  - CMD 0x81 -> ARG_CONTRAST; arg loads contrast. -> CMD.
  - CMD 0x21 -> ARG_COL0 loads col_start=arg[6:0] -> ARG_COL1 loads col_end=arg[6:0] and col_ptr<=col_start. -> CMD.
  - CMD 0x22 -> ARG_PAGE0 loads page_start=arg[2:0] -> ARG_PAGE1 loads page_end=arg[2:0] and page_ptr<=page_start. -> CMD.
  - Single-byte commands, state stays CMD:
    - 0xA6/0xA7: invert=0/1.
    - 0xAE/0xAF: display_on=0/1.
    - 0xB0-0xB7: page_ptr=byte[2:0]; page mode only, no-op otherwise.
    - 0x00-0x0F: col_ptr[3:0]=byte[3:0]; page mode only.
    - 0x10-0x17: col_ptr[6:4]=byte[2:0]; page mode only.
  - All other command bytes are single-byte no-ops.
- byte_valid=0: no state change; fb_we and frame_done are 0.
- Reset asserted mid-command or mid-frame: everything returns to reset values next cycle, and pending arguments are discarded.

Optional Feature:
- Macro FRAME_DONE_EN.
- Defined: frame_done pulses 1 cycle, coincident with fb_we, for the write whose address was (page_end,col_end) in horizontal mode, (page_end,col_end) in vertical mode, or col_end in page mode.
- Undefined: frame_done is tied to 0 and no comparison logic is built.

Test Plan:
- Reset, then 1024 data bytes 0x00..0xFF repeating -> fb_waddr 0..1023 in order, wdata matches, final address 1023; the next write goes to 0.
- 0x21,0x10,0x11 then 0x22,0x02,0x03 then 6 data bytes -> addresses 272,273,400,401,272,273.
- 0x20,0x01 then 9 data bytes -> addresses 0,128,256,...,896, then 1.
- 0x20,0x02; 0xB5; 0x03; 0x12 then 2 data bytes -> addresses 675,676.
- 0xA7, 0xAF, 0x81,0x33 -> invert=1, display_on=1, contrast=0x33. Then 0x81 followed by a data byte 0x55 -> write 0x55 occurs, contrast stays 0x33, and the next 0xA6 clears invert.
- With FRAME_DONE_EN: window 0..1 cols, 0..0 pages, 4 data bytes -> frame_done on writes 2 and 4. Reset asserted after 3 bytes -> next write address 0.
